// File: rtl/adder_pkg.sv
// Shared types and constants for the sliced sequential adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // A single-slice adder still needs a 1-bit index register.
    function automatic int idx_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module adder_slice
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o
);

    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[CHUNK];

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder summing CHUNK bits per clock behind a start/busy/done handshake.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seq_slice_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic             accept;
    logic             last;
    int               shamt;
    logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
    logic             cout_sl;
    logic [WIDTH-1:0] sum_sh, mask_sh;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (state_q == RUN) && (idx_q == LAST_IDX);

    // The single slice adder is steered to the active slice by shifting.
    assign shamt   = int'(idx_q) * CHUNK;
    assign a_sl    = CHUNK'(a_q >> shamt);
    assign b_sl    = CHUNK'(b_q >> shamt);
    assign sum_sh  = WIDTH'(sum_sl) << shamt;
    assign mask_sh = WIDTH'({CHUNK{1'b1}}) << shamt;

    adder_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a_i    (a_sl),
        .b_i    (b_sl),
        .cin_i  (carry_q),
        .s_o    (sum_sl),
        .cout_o (cout_sl)
    );

`ifdef ADDER_OVF_EN
    logic ovf_q, ovf_d;
    logic c_into_msb;

    // Carry into the MSB is recovered from the MSB sum bit.
    assign c_into_msb = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum_sl[CHUNK-1];
    assign ovf        = ovf_q;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                s_d     = (s_q & ~mask_sh) | sum_sh;
                carry_d = cout_sl;
                idx_d   = idx_q + IDXW'(1);
                if (last) begin
                    state_d = DONE;
                    cout_d  = cout_sl;
`ifdef ADDER_OVF_EN
                    ovf_d   = c_into_msb ^ cout_sl;
`endif
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            carry_d = cin;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operands only matter after an accepted start, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule
